// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one serial TX line between N_REQ byte requesters. Each frame goes to
// one requester, picked round-robin, and is sent as a start bit (0), eight data
// bits LSB first, an optional parity bit and a stop bit (1). An internal baud
// counter sets the length of every bit to CLKS_PER_BIT clocks.
//
// Handshake: requester i raises req_valid[i] and holds req_data[8i+7:8i]
// stable until req_ready[i] pulses high for one cycle. That pulse arrives in
// the first start-bit cycle and means the byte has been captured. The line
// samples requests only while idle, so changes during a frame have no effect.
//
// Ports:
//   clk        system clock, rising edge only
//   tx_rst     synchronous active-high reset
//   req_valid  [N_REQ]      per-requester byte available
//   req_data   [8*N_REQ]    per-requester byte, requester i at [8i +: 8]
//   req_ready  [N_REQ]      one-cycle one-hot accept pulse
//   grant_id   [ID_W]       index of the most recently granted requester
//   tx_out                  serial line, idles high
//   busy                    frame in progress
//   done                    one-cycle pulse in the idle cycle after a frame
//   dbg_state  [3]          current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 10417,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  localparam int ID_W        = $clog2(N_REQ),
  localparam int CNT_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 tx_rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic W_PAR_EN  = (PARITY_EN != 0);
  localparam logic W_PAR_ODD = (PARITY_ODD != 0);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_par;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [N_REQ-1:0]   r_ready;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic               w_term;
  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [7:0]         w_byte;
  int                 w_idx;
  logic [7:0]         w_bytes [N_REQ];

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  assign w_term = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Round-robin pick: scan from pointer+1 upward with wrap. The loop runs from
  // the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_byte  = '0;
    w_idx   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      if (req_valid[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_idx);
        w_byte  = w_bytes[ID_W'(w_idx)];
      end
    end
  end

  // Frame sequencer. All outputs are registered so that they change together
  // with the state: the start bit, busy and req_ready all appear in the cycle
  // right after the arbitration edge.
  always_ff @(posedge clk) begin
    if (tx_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_gid   <= '0;
      r_ready <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= '0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= '0;
          r_bit  <= '0;
          if (w_found) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_shift <= w_byte;
            r_par   <= (^w_byte) ^ W_PAR_ODD;
            r_gid   <= w_win;
            r_ptr   <= w_win;
            r_ready <= N_REQ'(1) << w_win;
          end
        end

        S_START: begin
          if (w_term) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_term) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              if (W_PAR_EN) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              // The next bit to send is shift[1]; it becomes shift[0] here.
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (w_term) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_term) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign grant_id  = r_gid;
  assign tx_out    = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler and frame sequencer for the UART transmit path. It shares one serial TX line between `N_REQ` byte requesters. It grants one requester per frame and builds the frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. It times each bit with an internal baud counter. It sits between the on-chip byte producers and the `tx_out` pin and reports frame status through `busy` and `done`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit, minimum 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity; used only when `PARITY_EN`=1.

Ports:
- `clk` input 1: system clock. One clock domain; all logic is on the rising edge.
- `tx_rst` input 1: reset, synchronous, active-high.
- `req_valid` input `N_REQ`: per-requester byte available. The requester holds it and its data until its `req_ready` pulses.
- `req_data` input 8*`N_REQ`: byte of requester i is `req_data[8i+7:8i]`.
- `req_ready` output `N_REQ`: one-cycle, one-hot accept pulse.
- `grant_id` output clog2(`N_REQ`): index of the last granted requester.
- `tx_out` output 1: serial line, idles high.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- Reset values: `tx_out`=1, `busy`=0, `done`=0, `req_ready`=0, `grant_id`=0. The internal last-grant pointer resets to `N_REQ`-1, so requester 0 has first priority. The baud counter and bit index reset to 0.
- IDLE behaviour:
  - `tx_out`=1.
  - If any `req_valid` bit is high, the winner is the first set bit found scanning upward from (pointer+1), with wrap-around.
  - On that edge the block latches the winner's byte, loads `grant_id` and the pointer with the winner's index, drives the winner's `req_ready` high for the next cycle only, and enters START.
  - If no request is present, the block stays in IDLE.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx_out`=`shift[0]` for `CLKS_PER_BIT` cycles per bit, then shift right. After bit index 7 the FSM goes to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: `tx_out` = (XOR of the latched byte) XOR `PARITY_ODD`, held for `CLKS_PER_BIT` cycles.
- STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles, then IDLE with `done`=1 for that one IDLE cycle.
- Baud counter:
  - Width is clog2(`CLKS_PER_BIT`).
  - It counts 0..`CLKS_PER_BIT`-1 in every non-IDLE state.
  - The bit boundary is at terminal count. There the counter wraps to 0 and the state or bit index advances.
- `busy`=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- Changes on `req_valid` or `req_data` during a frame are ignored. Only IDLE samples requests.
- A requester that drops `req_valid` before it is granted is simply skipped. No error is flagged.

## Timing
- Request sampled in IDLE at cycle t:
  - In cycle t+1, `req_ready[g]`=1, `busy`=1 and `tx_out`=0 (the start bit begins).
  - The requester may drop `req_valid` from cycle t+2.
- Frame length from the first start-bit cycle to the last stop-bit cycle is (10+`PARITY_EN`)×`CLKS_PER_BIT` cycles.
- `done` is high in the first cycle after the last stop-bit cycle, with `busy`=0 in that cycle.
- That same cycle is the IDLE arbitration cycle. A pending request therefore starts its start bit one clock later, giving exactly one idle-high clock between back-to-back frames.
- `done` and `req_ready` never assert in the same cycle.
- `tx_rst` mid-frame:
  - In the next cycle every output takes its reset value.
  - No `done` pulse is issued.
  - The aborted byte is lost, because it was already acknowledged.
- `tx_rst` overrides a simultaneous request. No grant is made in the reset cycle.

## Test plan
- Single byte: `CLKS_PER_BIT`=16, `PARITY_EN`=0, requester 0 sends 0xA5 -> `tx_out` bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles. `req_ready[0]` pulses in the first start cycle; `done` pulses 160 cycles after the start-bit fall.
- Round-robin: all four `req_valid` held high for 5 frames -> `grant_id` sequence 0,1,2,3,0, with exactly one idle-high clock between frames.
- Parity: `PARITY_EN`=1, byte 0xA5 -> parity bit 0 with `PARITY_ODD`=0 and 1 with `PARITY_ODD`=1. Frame is 176 cycles at `CLKS_PER_BIT`=16.
- Skip and wrap: last grant 2, only requesters 1 and 3 valid -> grant 3, then grant 1.
- Reset mid-DATA: `tx_rst` asserted at bit 4 -> next cycle `tx_out`=1, `busy`=0, no `done`. A fresh request from requester 0 is then granted first.
- Ignore during frame: toggle `req_data` and `req_valid` of the granted requester mid-frame -> transmitted byte unchanged and no extra `req_ready`.
